// File: rtl/arbitro_fifos_if.sv
// arbitro_fifos_if: input-FIFO heads, output-FIFO flags and the pop/push strobes of the arbiter
interface arbitro_fifos_if #(parameter int DATA_W = 6);
    logic [3:0]          in_empty;
    logic [4*DATA_W-1:0] in_data;
    logic [3:0]          out_almost_full;
    logic [3:0]          pop;
    logic [3:0]          push;
    logic [DATA_W-1:0]   data_out;
    modport master (input in_empty, in_data, out_almost_full, output pop, push, data_out);
    modport slave (output in_empty, in_data, out_almost_full, input pop, push, data_out);
endinterface

// File: rtl/arbitro_fifos.sv
// arbitro_fifos: round-robin burst arbiter moving words from four input FIFOs to four output FIFOs
module arbitro_fifos #(
    parameter int DATA_W = 6,
    parameter int BURST  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    arbitro_fifos_if.master bus,
    output logic            idle
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t     state, state_n;
    logic [1:0] ptr, owner, start, sel, gnt_idx, gnt_dest;
    logic [3:0] cnt, elig;
    logic       gnt_v, keep, rot;

    function automatic logic [1:0] dest(input logic [4*DATA_W-1:0] data, input logic [1:0] i);
        return data[int'(i)*DATA_W + DATA_W-2 +: 2];
    endfunction

    // Scans downward so the smallest offset from s wins; s itself is tried first, s-1 last
    function automatic logic [1:0] search(input logic [3:0] e, input logic [1:0] s);
        logic [1:0] r;
        r = s;
        for (int k = 3; k >= 0; k--)
            if (e[s + 2'(k)]) r = s + 2'(k);
        return r;
    endfunction

    // Eligibility: held in reset or disabled means nothing may be popped
    always_comb begin
        elig = '0;
        for (int i = 0; i < 4; i++)
            elig[i] = reset & enable & ~bus.in_empty[i] & ~bus.out_almost_full[dest(bus.in_data, 2'(i))];
    end

    // Grant decision: continue the burst or rotate to the next eligible input without a bubble
    always_comb begin
        keep     = (state == GRANT) && elig[owner] && (cnt < 4'(BURST));
        rot      = (state == GRANT) && !keep;
        start    = (state == GRANT) ? owner + 2'd1 : ptr;
        sel      = search(elig, start);
        gnt_v    = |elig;
        gnt_idx  = keep ? owner : sel;
        gnt_dest = dest(bus.in_data, gnt_idx);
    end

    // Next state: stay granting while anyone is eligible
    always_comb state_n = gnt_v ? GRANT : IDLE;

    // Pop output: combinational one-hot to the granted input
    always_comb bus.pop = gnt_v ? 4'b0001 << gnt_idx : 4'b0000;

    // State register with owner, burst count and round-robin pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
            owner <= '0;
        end else begin
            state <= state_n;
            if (gnt_v) owner <= gnt_idx;
            cnt <= !gnt_v ? 4'd0 : keep ? cnt + 4'd1 : 4'd1;
            if (rot && enable) ptr <= owner + 2'd1;
        end
    end

    // One-cycle pipeline from pop to push; data_out holds between pushes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.push     <= '0;
            bus.data_out <= '0;
        end else begin
            bus.push <= gnt_v ? 4'b0001 << gnt_dest : 4'b0000;
            if (gnt_v) bus.data_out <= bus.in_data[int'(gnt_idx)*DATA_W +: DATA_W];
        end
    end

    assign idle = (state == IDLE) && (bus.in_empty == 4'hF) && (bus.push == 4'h0);
endmodule

// File: tb/tb_arbitro_fifos.sv
// tb_arbitro_fifos: directed checks of arbitration order, backpressure, enable drop and reset
module tb_arbitro_fifos;
    localparam int W = 6;
    logic clk = 0, reset = 0, enable = 0, idle;
    logic [1:0] dst [4];
    int n_tests = 0, n_fail = 0;

    arbitro_fifos_if #(.DATA_W(W)) bus ();
    arbitro_fifos #(.DATA_W(W), .BURST(4)) dut (.clk(clk), .reset(reset), .enable(enable), .bus(bus.master), .idle(idle));

    always #5 clk = ~clk;

    function automatic logic [W-1:0] word(input int i);
        return {dst[i], 4'(i + 5)};
    endfunction

    // Head words: destination in the MSBs, a per-input tag below
    always_comb begin
        bus.in_data = '0;
        for (int i = 0; i < 4; i++) bus.in_data[i*W +: W] = word(i);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One arbitration cycle: expected pop now, expected push/data_out after the edge
    task automatic step(input string tag, input logic [3:0] exp_pop);
        int idx;
        logic [1:0] ed;
        logic [W-1:0] ew;
        idx = 0;
        #1 check({tag, "_pop"}, 32'(bus.pop), 32'(exp_pop));
        for (int i = 0; i < 4; i++) if (exp_pop[i]) idx = i;
        ed = dst[idx];
        ew = word(idx);
        tick();
        check({tag, "_push"}, 32'(bus.push), exp_pop != 0 ? 32'(4'b0001 << ed) : 32'd0);
        if (exp_pop != 0) check({tag, "_data"}, 32'(bus.data_out), 32'(ew));
    endtask

    task automatic do_reset();
        bus.in_empty = 4'hF;
        bus.out_almost_full = 4'h0;
        enable = 0;
        #1 reset = 0;
        #1 reset = 1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) dst[i] = 2'(i);
        bus.in_empty = 4'hF;
        bus.out_almost_full = 4'h0;
        #3;
        check("rst_pop", 32'(bus.pop), 0);
        check("rst_push", 32'(bus.push), 0);
        check("rst_data", 32'(bus.data_out), 0);
        check("rst_idle", 32'(idle), 1);
        tick();
        reset = 1;

        // Single word from input 0 to output 2
        dst[0] = 2'b10;
        enable = 1;
        bus.in_empty = 4'b1110;
        step("single", 4'b0001);
        check("single_word", 32'(bus.data_out), 32'(6'b100101));
        bus.in_empty = 4'hF;
        #1 check("single_busy", 32'(idle), 0);
        step("single_drain", 4'b0000);
        check("single_idle", 32'(idle), 1);

        // Round robin with bursts of four
        do_reset();
        for (int i = 0; i < 4; i++) dst[i] = 2'(i);
        enable = 1;
        bus.in_empty = 4'h0;
        for (int k = 0; k < 17; k++) step("rr", 4'b0001 << ((k / 4) % 4));
        // Asynchronous reset between edges drops the in-flight word
        #1 bus.in_empty = 4'hF;
        reset = 0;
        #1;
        check("arst_pop", 32'(bus.pop), 0);
        check("arst_push", 32'(bus.push), 0);
        check("arst_data", 32'(bus.data_out), 0);
        check("arst_idle", 32'(idle), 1);
        reset = 1;

        // Backpressure on input 0's destination mid-burst
        do_reset();
        dst[0] = 2; dst[1] = 1; dst[2] = 3; dst[3] = 0;
        enable = 1;
        bus.in_empty = 4'h0;
        step("bp", 4'b0001);
        step("bp", 4'b0001);
        bus.out_almost_full = 4'b0100;
        step("bp_af", 4'b0010);
        bus.out_almost_full = 4'b0000;
        for (int k = 0; k < 3; k++) step("bp1", 4'b0010);
        for (int k = 0; k < 4; k++) step("bp2", 4'b0100);
        for (int k = 0; k < 4; k++) step("bp3", 4'b1000);
        step("bp_ret", 4'b0001);

        // Enable drop with the pointer left at input 1
        do_reset();
        for (int i = 0; i < 4; i++) dst[i] = 2'(i);
        enable = 1;
        bus.in_empty = 4'h0;
        for (int k = 0; k < 4; k++) step("en0", 4'b0001);
        step("en1", 4'b0010);
        step("en1", 4'b0010);
        enable = 0;
        #1 check("en_inflight", 32'(bus.push), 32'(4'b0010));
        step("en_off", 4'b0000);
        step("en_off", 4'b0000);
        enable = 1;
        for (int k = 0; k < 4; k++) step("en_back", 4'b0010);
        step("en_next", 4'b0100);

        // Sole requester is regranted across burst boundaries
        do_reset();
        enable = 1;
        bus.in_empty = 4'b0111;
        for (int k = 0; k < 9; k++) step("sole", 4'b1000);
        bus.in_empty = 4'hF;
        step("sole_end", 4'b0000);
        bus.in_empty = 4'h0;
        step("sole_ptr", 4'b0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
